led_strip_rx: RTL and testbench
===============================

Name: led_strip_rx

Overview:
- Receiver and decoder for the two-wire LED-strip serial protocol: a clock line plus a data line carrying 32-bit frames.
- Frame sequence: 32-bit all-zero start frame, then NUM_LEDS 32-bit LED words (header 3'b111, 5-bit brightness, three 8-bit colours), then trailing zeros.
- Oversamples both lines on the system clock and reconstructs each LED word with its index.
- Flags complete frames and protocol errors. Used as an on-chip loopback monitor for the matrix driver and as the input stage of a downstream strip/matrix node.

Parameters:
- NUM_LEDS, 64, LED words per frame (1..256).
- SYNC_STAGES, 2, synchroniser depth for led_clk and led_data (≥2).
- TIMEOUT_CYCLES, 4096, clk cycles without a led_clk edge before an in-frame abort.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- led_clk  input  1  strip clock line, asynchronous to clk.
- led_data  input  1  strip data line; launched on the led_clk rising edge.
- led_word  output  32  last received LED word, MSB = first bit on the wire.
- led_index  output  8  index of led_word, 0..NUM_LEDS-1.
- led_valid  output  1  one-cycle strobe; led_word and led_index are valid.
- frame_done  output  1  one-cycle strobe after word NUM_LEDS-1 is accepted.
- frame_error  output  1  one-cycle strobe on a protocol error or timeout.
- locked  output  1  high in states SYNCED and PIXEL.

Behaviour:
- Reset (async, active-high): clears all state immediately. Synchroniser flops = 0, state = HUNT. Every output = 0 while reset is asserted and after release, until new activity.
- Synchronisation: led_clk and led_data each pass through SYNC_STAGES flops. Edges are detected on the synchronised led_clk only.
- Bit sampling: data is sampled on the synchronised led_clk falling edge, i.e. mid-bit, since the transmitter changes data on the rising edge.
- Oversampling requirement: each led_clk phase must last ≥2 clk cycles. Behaviour at faster line rates is undefined.
- Shift register: 32 bits, MSB first. A 5-bit bit counter wraps 31→0.
- HUNT:
  - 6-bit zero_run counter increments on each sampled 0 and clears on a sampled 1.
  - zero_run reaching 32 → SYNCED; bit counter = 0, word counter = 0.
- SYNCED:
  - Collects 32-bit words.
  - All-zero word: treated as an extended start frame; remain in SYNCED, no strobe.
  - Word with bits[31:29] = 3'b111: accepted as word 0 → PIXEL.
  - Any other word: frame_error strobe → HUNT with zero_run = 0.
- PIXEL:
  - Each 32-bit word with header 3'b111 is accepted; word counter increments.
  - Bad header: frame_error strobe → HUNT. Words already strobed are not retracted.
  - After word NUM_LEDS-1 is accepted: frame_done strobes in the same cycle as that word's led_valid → HUNT with zero_run = 0. Trailing zeros then count toward the next start frame.
- Output timing:
  - The 32nd bit is sampled in edge-detect cycle E. led_valid, led_word, led_index update in cycle E+1.
  - led_word and led_index hold until the next accepted word.
- Timeout:
  - In SYNCED or PIXEL, an idle counter clears on every led_clk edge (either polarity).
  - Reaching TIMEOUT_CYCLES → frame_error strobe → HUNT.
  - HUNT never times out.
- Simultaneous events:
  - A timeout and a word completion cannot coincide, because a completion requires an edge.
  - frame_error and led_valid never assert in the same cycle.
- Counter widths: word counter 8 bits and compared against NUM_LEDS-1; it never wraps within a frame.

Test Plan:
- Full frame: 32 zeros, then 64 words 0xF0000000 except index 5 = 0xF0007000, then 64 zeros. Expect 64 led_valid strobes with index 0..63 in order, index 5 word = 0xF0007000, frame_done once coincident with index 63, frame_error never, locked low after.
- Extended start: 96 zeros followed by the same frame. Expect an identical result with no error; locked rises after the 32nd zero.
- Broken preamble: 31 zeros, one 1, then a 32-zero start and frame. Expect lock only after the second zero run and all 64 words decoded.
- Bad header: word 3 = 0x70000000. Expect led_valid for indices 0..2, frame_error on word 3, no frame_done. The next clean frame decodes fully.
- Stall: hold led_clk mid-word at index 10 for TIMEOUT_CYCLES+5 clks. Expect one frame_error, locked = 0, no led_valid for index 10.
- Async reset mid-frame at word 20, asserted away from any clk edge. Expect all outputs 0 immediately; after release, a fresh frame decodes from index 0 with no spurious strobes.

Source files
------------

// File: rtl/led_strip_rx.sv
// ---------------------------------------------------------------------------
// led_strip_rx
//
// Receiver/decoder for the two-wire LED-strip serial protocol (clock + data,
// 32-bit frames). Both lines are oversampled on clk. Each frame has a 32-bit
// all-zero start frame, then NUM_LEDS LED words (3'b111 header, 5-bit
// brightness, three 8-bit colours), then trailing zeros.
//
// Parameters:
//   NUM_LEDS        LED words per frame (1..256)
//   SYNC_STAGES     synchroniser depth for led_clk / led_data (>= 2)
//   TIMEOUT_CYCLES  clk cycles without a led_clk edge before an in-frame abort
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   led_clk      in   strip clock line (asynchronous to clk)
//   led_data     in   strip data line, launched on the led_clk rising edge
//   led_word     out  [31:0] last accepted LED word, MSB = first bit on wire
//   led_index    out  [7:0]  index of led_word
//   led_valid    out  one-cycle strobe, led_word / led_index updated
//   frame_done   out  one-cycle strobe with the led_valid of word NUM_LEDS-1
//   frame_error  out  one-cycle strobe on a bad header or timeout
//   locked       out  high while in SYNCED or PIXEL
// ---------------------------------------------------------------------------
module led_strip_rx #(
    parameter int NUM_LEDS       = 64,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        led_clk,
    input  logic        led_data,
    output logic [31:0] led_word,
    output logic [7:0]  led_index,
    output logic        led_valid,
    output logic        frame_done,
    output logic        frame_error,
    output logic        locked
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        LAST_IDX  = 8'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNCED = 2'd1,
        PIXEL  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Synchronisers. Both lines use the same depth so that data stays
    // aligned with the clock edge it belongs to.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], led_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], led_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    logic s_clk;
    logic s_data;
    logic clk_fall;
    logic clk_edge;

    assign s_clk    = clk_sync_q[SYNC_STAGES-1];
    assign s_data   = data_sync_q[SYNC_STAGES-1];
    // Transmitter launches on the rising edge, so the falling edge is mid-bit.
    assign clk_fall = clk_prev_q & ~s_clk;
    assign clk_edge = clk_prev_q ^ s_clk;

    // -----------------------------------------------------------------------
    // Frame state machine and registered outputs
    // -----------------------------------------------------------------------
    state_t            state_q;
    logic [5:0]        zero_run_q;
    logic [4:0]        bit_cnt_q;
    logic [7:0]        word_cnt_q;
    logic [31:0]       shift_q;
    logic [IDLE_W-1:0] idle_q;

    logic [31:0] led_word_q;
    logic [7:0]  led_index_q;
    logic        led_valid_q;
    logic        frame_done_q;
    logic        frame_error_q;
    logic        locked_q;

    logic [31:0] word_d;
    logic        word_end;
    logic        hdr_ok;

    // word_d is the complete word including the bit sampled this cycle.
    assign word_d   = {shift_q[30:0], s_data};
    assign word_end = clk_fall && (bit_cnt_q == 5'd31);
    assign hdr_ok   = (word_d[31:29] == 3'b111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HUNT;
            zero_run_q    <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            shift_q       <= '0;
            idle_q        <= '0;
            led_word_q    <= '0;
            led_index_q   <= '0;
            led_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            led_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;

            if (clk_fall) begin
                shift_q   <= word_d;
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end

            case (state_q)
                HUNT: begin
                    idle_q <= '0;
                    if (clk_fall) begin
                        if (s_data) begin
                            zero_run_q <= '0;
                        end else if (zero_run_q == 6'd31) begin
                            // This zero is the 32nd in a row: start frame seen,
                            // word boundaries align from the next bit.
                            zero_run_q <= '0;
                            bit_cnt_q  <= '0;
                            word_cnt_q <= '0;
                            state_q    <= SYNCED;
                            locked_q   <= 1'b1;
                        end else begin
                            zero_run_q <= zero_run_q + 6'd1;
                        end
                    end
                end

                SYNCED, PIXEL: begin
                    // Word completion needs an edge, so it never overlaps
                    // with the timeout branch below.
                    if (clk_edge) begin
                        idle_q <= '0;
                    end else if (idle_q == IDLE_LAST) begin
                        idle_q        <= '0;
                        frame_error_q <= 1'b1;
                        zero_run_q    <= '0;
                        state_q       <= HUNT;
                        locked_q      <= 1'b0;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end

                    if (word_end) begin
                        if (state_q == SYNCED && word_d == 32'd0) begin
                            // Extended start frame: keep waiting for word 0.
                            state_q <= SYNCED;
                        end else if (hdr_ok) begin
                            led_valid_q <= 1'b1;
                            led_word_q  <= word_d;
                            led_index_q <= word_cnt_q;
                            word_cnt_q  <= word_cnt_q + 8'd1;
                            if (word_cnt_q == LAST_IDX) begin
                                frame_done_q <= 1'b1;
                                zero_run_q   <= '0;
                                state_q      <= HUNT;
                                locked_q     <= 1'b0;
                            end else begin
                                state_q <= PIXEL;
                            end
                        end else begin
                            frame_error_q <= 1'b1;
                            zero_run_q    <= '0;
                            state_q       <= HUNT;
                            locked_q      <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q    <= HUNT;
                    zero_run_q <= '0;
                    locked_q   <= 1'b0;
                end
            endcase
        end
    end

    assign led_word    = led_word_q;
    assign led_index   = led_index_q;
    assign led_valid   = led_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_led_strip_rx.sv
// ---------------------------------------------------------------------------
// tb_led_strip_rx
//
// Scoreboard bench for led_strip_rx. Stimulus tasks push the expected
// {frame_done, index, word} of each LED word before driving it; a negedge
// monitor pops and compares on every led_valid. Error / done strobes are
// counted and compared per scenario.
// ---------------------------------------------------------------------------
module tb_led_strip_rx;

    localparam int NL   = 64;
    localparam int TO   = 4096;
    localparam int HALF = 2;   // clk cycles per led_clk phase

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        led_clk = 1'b0;
    logic        led_data = 1'b0;
    logic [31:0] led_word;
    logic [7:0]  led_index;
    logic        led_valid;
    logic        frame_done;
    logic        frame_error;
    logic        locked;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int done_seen = 0;
    int e0, d0;

    logic [40:0] sb[$];
    logic [40:0] mon_e;

    led_strip_rx #(
        .NUM_LEDS      (NL),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .led_clk    (led_clk),
        .led_data   (led_data),
        .led_word   (led_word),
        .led_index  (led_index),
        .led_valid  (led_valid),
        .frame_done (frame_done),
        .frame_error(frame_error),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (led_valid) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("led_word", 64'(led_word), 64'(mon_e[31:0]));
                chk("led_index", 64'(led_index), 64'(mon_e[39:32]));
                chk("frame_done", 64'(frame_done), 64'(mon_e[40]));
            end
            chk("err_with_valid", 64'(frame_error), 64'd0);
        end
        if (frame_done) begin
            done_seen++;
            chk("done_with_valid", 64'(led_valid), 64'd1);
        end
        if (frame_error) err_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Data changes together with the rising edge; the DUT samples at the fall.
    task automatic send_bit(input logic b);
        led_data = b;
        led_clk  = 1'b1;
        tick(HALF);
        led_clk  = 1'b0;
        tick(HALF);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        repeat (n) send_bit(1'b0);
    endtask

    // Test frame: 0xF0000000 everywhere except index 5 = 0xF0007000.
    // bad_idx sends 0x70000000 there and stops; stop_idx sends only the
    // first part_bits bits of that word and stops.
    task automatic send_frame(input int bad_idx, input int stop_idx, input int part_bits);
        logic [31:0] w;
        for (int i = 0; i < NL; i++) begin
            w = (i == 5) ? 32'hF000_7000 : 32'hF000_0000;
            if (i == stop_idx) begin
                for (int b = 31; b > 31 - part_bits; b--) send_bit(w[b]);
                return;
            end
            if (i == bad_idx) begin
                send_word(32'h7000_0000);
                return;
            end
            sb.push_back({(i == NL - 1), 8'(i), w});
            send_word(w);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        led_clk  = 1'b0;
        led_data = 1'b0;
        tick(3);
        reset    = 1'b0;
        tick(3);
    endtask

    task automatic mark();
        e0 = err_seen;
        d0 = done_seen;
    endtask

    task automatic frame_ok(input string tag);
        tick(6);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_done"}, 64'(done_seen - d0), 64'd1);
        chk({tag, "_err"}, 64'(err_seen - e0), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_word", 64'(led_word), 64'd0);
        chk("rst_index", 64'(led_index), 64'd0);
        chk("rst_strobes", 64'({led_valid, frame_done, frame_error}), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        reset = 1'b0;
        tick(3);
        chk("post_rst_outs", 64'({led_valid, frame_done, frame_error, locked}), 64'd0);

        // Full frame
        mark();
        send_zeros(32);
        send_frame(-1, -1, 0);
        frame_ok("full");
        send_zeros(64);

        // Extended start: 96 zeros
        do_reset();
        mark();
        send_zeros(31);
        tick(4);
        chk("ext_unlocked_31", 64'(locked), 64'd0);
        send_zeros(1);
        tick(4);
        chk("ext_locked_32", 64'(locked), 64'd1);
        send_zeros(64);
        chk("ext_locked_96", 64'(locked), 64'd1);
        send_frame(-1, -1, 0);
        frame_ok("ext");

        // Broken preamble
        do_reset();
        mark();
        send_zeros(31);
        send_bit(1'b1);
        tick(4);
        chk("brk_unlocked_one", 64'(locked), 64'd0);
        send_zeros(31);
        tick(4);
        chk("brk_unlocked_31", 64'(locked), 64'd0);
        send_zeros(1);
        tick(4);
        chk("brk_locked", 64'(locked), 64'd1);
        send_frame(-1, -1, 0);
        frame_ok("brk");

        // Bad header at word 3, then a clean frame
        do_reset();
        mark();
        send_zeros(32);
        send_frame(3, -1, 0);
        tick(6);
        chk("bad_sb_empty", 64'(sb.size()), 64'd0);
        chk("bad_err", 64'(err_seen - e0), 64'd1);
        chk("bad_done", 64'(done_seen - d0), 64'd0);
        chk("bad_locked", 64'(locked), 64'd0);
        mark();
        send_zeros(32);
        send_frame(-1, -1, 0);
        frame_ok("bad_next");

        // Stall mid-word at index 10
        do_reset();
        mark();
        send_zeros(32);
        send_frame(-1, 10, 16);
        chk("stall_locked_pre", 64'(locked), 64'd1);
        tick(TO + 5);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);
        chk("stall_err", 64'(err_seen - e0), 64'd1);
        chk("stall_done", 64'(done_seen - d0), 64'd0);
        chk("stall_locked", 64'(locked), 64'd0);

        // Async reset mid-frame at word 20, away from a clk edge
        do_reset();
        mark();
        send_zeros(32);
        send_frame(-1, 20, 10);
        tick(2);
        chk("arst_sb_empty", 64'(sb.size()), 64'd0);
        chk("arst_locked_pre", 64'(locked), 64'd1);
        chk("arst_word_pre", 64'(led_word), 64'hF000_0000);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_word", 64'(led_word), 64'd0);
        chk("arst_index", 64'(led_index), 64'd0);
        chk("arst_strobes", 64'({led_valid, frame_done, frame_error}), 64'd0);
        chk("arst_locked", 64'(locked), 64'd0);
        tick(3);
        led_clk  = 1'b0;
        led_data = 1'b0;
        reset    = 1'b0;
        tick(3);
        mark();
        send_zeros(32);
        send_frame(-1, -1, 0);
        frame_ok("arst_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
